// File: rtl/sm4_round_scheduler_if.sv
// Control bus between the SM4 round scheduler and the execute stage / SM4 datapath.
// The scheduler takes the slave side; the requester and datapath together form the master side.
interface sm4_round_scheduler_if #(
    parameter int CNT_W = 6
);
    logic             start_i;
    logic             decrypt_i;
    logic             new_key_i;
    logic             abort_i;
    logic             busy_o;
    logic             hold_pipeline_o;
    logic             key_load_o;
    logic             key_round_en_o;
    logic             rk_wr_en_o;
    logic [4:0]       rk_addr_o;
    logic             data_load_o;
    logic             data_round_en_o;
    logic [CNT_W-1:0] round_o;
    logic             save_data_o;
    logic             done_o;
    logic             key_ready_o;

    modport master (
        output start_i, decrypt_i, new_key_i, abort_i,
        input  busy_o, hold_pipeline_o, key_load_o, key_round_en_o, rk_wr_en_o,
               rk_addr_o, data_load_o, data_round_en_o, round_o, save_data_o,
               done_o, key_ready_o
    );

    modport slave (
        input  start_i, decrypt_i, new_key_i, abort_i,
        output busy_o, hold_pipeline_o, key_load_o, key_round_en_o, rk_wr_en_o,
               rk_addr_o, data_load_o, data_round_en_o, round_o, save_data_o,
               done_o, key_ready_o
    );
endinterface

// File: rtl/sm4_round_scheduler.sv
// SM4 sequencing controller: optional key expansion, then ROUNDS data rounds.
// The expanded key is cached in round-key RAM so repeated same-key operations skip expansion.
module sm4_round_scheduler #(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = 6
) (
    input  logic                 clk,
    input  logic                 rest,
    sm4_round_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KLOAD  = 3'd1,
        KEXP   = 3'd2,
        DLOAD  = 3'd3,
        DROUND = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode, mode_nxt;
    logic             key_ready, key_ready_nxt;
    logic             last;

    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mode      <= mode_nxt;
            key_ready <= key_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mode_nxt      = mode;
        key_ready_nxt = key_ready;
        case (state)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    mode_nxt  = bus.decrypt_i;
                    cnt_nxt   = '0;
                    state_nxt = (bus.new_key_i || !key_ready) ? KLOAD : DLOAD;
                end
            end
            KLOAD: begin
                cnt_nxt = '0;
                if (bus.abort_i) begin
                    state_nxt     = IDLE;
                    key_ready_nxt = 1'b0;
                end else begin
                    state_nxt = KEXP;
                end
            end
            KEXP: begin
                // An aborted expansion leaves a partial key in RAM, so the cache is invalidated.
                if (bus.abort_i) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    key_ready_nxt = 1'b0;
                end else if (last) begin
                    state_nxt     = DLOAD;
                    cnt_nxt       = '0;
                    key_ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DLOAD: begin
                cnt_nxt   = '0;
                state_nxt = bus.abort_i ? IDLE : DROUND;
            end
            DROUND: begin
                if (bus.abort_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last) begin
                    state_nxt = FINISH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.busy_o          = (state != IDLE);
        bus.hold_pipeline_o = 1'b0;
        bus.key_load_o      = 1'b0;
        bus.key_round_en_o  = 1'b0;
        bus.rk_wr_en_o      = 1'b0;
        bus.rk_addr_o       = '0;
        bus.data_load_o     = 1'b0;
        bus.data_round_en_o = 1'b0;
        bus.round_o         = '0;
        bus.save_data_o     = 1'b0;
        bus.done_o          = 1'b0;
        bus.key_ready_o     = key_ready;
        case (state)
            // Stall starts in the request cycle itself, before the state register moves.
            IDLE:   bus.hold_pipeline_o = bus.start_i && !bus.abort_i && !rest;
            KLOAD: begin
                bus.hold_pipeline_o = 1'b1;
                bus.key_load_o      = 1'b1;
            end
            KEXP: begin
                bus.hold_pipeline_o = 1'b1;
                bus.key_round_en_o  = 1'b1;
                bus.rk_wr_en_o      = 1'b1;
                bus.rk_addr_o       = 5'(cnt);
                bus.round_o         = cnt;
            end
            DLOAD: begin
                bus.hold_pipeline_o = 1'b1;
                bus.data_load_o     = 1'b1;
            end
            DROUND: begin
                bus.hold_pipeline_o = 1'b1;
                bus.data_round_en_o = 1'b1;
                bus.rk_addr_o       = mode ? 5'(LAST - cnt) : 5'(cnt);
                bus.round_o         = cnt;
            end
            FINISH: begin
                bus.save_data_o = 1'b1;
                bus.done_o      = 1'b1;
            end
            default: bus.busy_o = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_sm4_round_scheduler.sv
// Directed bench for sm4_round_scheduler: full sequences, cached key, aborts, async reset.
module tb_sm4_round_scheduler;
    localparam logic [9:0] F_BUSY = 10'h200;
    localparam logic [9:0] F_HOLD = 10'h100;
    localparam logic [9:0] F_KLD  = 10'h080;
    localparam logic [9:0] F_KRND = 10'h040;
    localparam logic [9:0] F_RKWR = 10'h020;
    localparam logic [9:0] F_DLD  = 10'h010;
    localparam logic [9:0] F_DRND = 10'h008;
    localparam logic [9:0] F_SAVE = 10'h004;
    localparam logic [9:0] F_DONE = 10'h002;
    localparam logic [9:0] F_KRDY = 10'h001;

    logic clk;
    logic rest;
    int   vectors;
    int   miscompares;

    sm4_round_scheduler_if #(.CNT_W(6)) bus ();

    sm4_round_scheduler #(.ROUNDS(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] ef, input logic [4:0] ea,
                       input logic [5:0] er);
        logic [9:0] of;
        of = {bus.busy_o, bus.hold_pipeline_o, bus.key_load_o, bus.key_round_en_o,
              bus.rk_wr_en_o, bus.data_load_o, bus.data_round_en_o, bus.save_data_o,
              bus.done_o, bus.key_ready_o};
        vectors++;
        assert ({of, bus.rk_addr_o, bus.round_o} === {ef, ea, er})
        else begin
            miscompares++;
            $error("FAIL %s: observed flags=%b addr=%0d round=%0d, expected flags=%b addr=%0d round=%0d",
                   tag, of, bus.rk_addr_o, bus.round_o, ef, ea, er);
        end
    endtask

    // Advance one clock, drive this cycle's inputs, then let outputs settle for checking.
    task automatic step(input logic s, input logic d, input logic n, input logic a);
        @(posedge clk);
        #2;
        bus.start_i   = s;
        bus.decrypt_i = d;
        bus.new_key_i = n;
        bus.abort_i   = a;
        #1;
    endtask

    task automatic run_op(input string tag, input logic dec, input logic nk, input logic kr_in,
                          input logic pulse_start, input int abort_kexp, input int abort_dr);
        logic [9:0] kr;
        logic       a;
        logic       s;
        kr = kr_in ? F_KRDY : 10'h000;
        step(1'b1, dec, nk, 1'b0);
        chk($sformatf("%s/req", tag), F_HOLD | kr, 5'd0, 6'd0);
        if (nk || !kr_in) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("%s/kload", tag), F_BUSY | F_HOLD | F_KLD | kr, 5'd0, 6'd0);
            for (int i = 0; i < 32; i++) begin
                a = (i == abort_kexp);
                step(1'b0, 1'b0, 1'b0, a);
                chk($sformatf("%s/kexp%0d", tag, i), F_BUSY | F_HOLD | F_KRND | F_RKWR | kr,
                    5'(i), 6'(i));
                if (a) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk($sformatf("%s/kabort_idle", tag), 10'h000, 5'd0, 6'd0);
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    chk($sformatf("%s/kabort_idle2", tag), 10'h000, 5'd0, 6'd0);
                    return;
                end
            end
            kr = F_KRDY;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("%s/dload", tag), F_BUSY | F_HOLD | F_DLD | kr, 5'd0, 6'd0);
        for (int i = 0; i < 32; i++) begin
            a = (i == abort_dr);
            s = pulse_start && i[0];
            step(s, s ? !dec : 1'b0, s, a);
            chk($sformatf("%s/dround%0d", tag, i), F_BUSY | F_HOLD | F_DRND | kr,
                dec ? 5'(31 - i) : 5'(i), 6'(i));
            if (a) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk($sformatf("%s/dabort_idle", tag), kr, 5'd0, 6'd0);
                step(1'b0, 1'b0, 1'b0, 1'b0);
                chk($sformatf("%s/dabort_idle2", tag), kr, 5'd0, 6'd0);
                return;
            end
        end
        // Start and abort both raised during FINISH: neither may have any effect.
        step(1'b1, !dec, 1'b0, 1'b1);
        chk($sformatf("%s/finish", tag), F_BUSY | F_SAVE | F_DONE | kr, 5'd0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("%s/idle", tag), kr, 5'd0, 6'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rest          = 1'b1;
        bus.start_i   = 1'b0;
        bus.decrypt_i = 1'b0;
        bus.new_key_i = 1'b0;
        bus.abort_i   = 1'b0;
        #1;
        chk("reset", 10'h000, 5'd0, 6'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rest = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_reset", 10'h000, 5'd0, 6'd0);

        // Cold start: key expansion forced by empty cache, encrypt order.
        run_op("enc_cold", 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        // Cached key, decrypt order.
        run_op("dec_warm", 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        // Start/decrypt toggled during data rounds must not disturb anything.
        run_op("enc_pulses", 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);

        // Abort in IDLE suppresses the same-cycle start.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("idle_abort_req", F_KRDY, 5'd0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_abort_stay", F_KRDY, 5'd0, 6'd0);

        // Forced re-expansion aborted at round 10 drops the cached key.
        run_op("kexp_abort", 1'b0, 1'b1, 1'b1, 1'b0, 10, -1);
        run_op("reexpand", 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        // Data abort at round 5 keeps the key.
        run_op("dr_abort", 1'b0, 1'b0, 1'b1, 1'b0, -1, 5);
        run_op("after_dr_abort", 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);

        // Asynchronous reset in the middle of data rounds.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_req", F_HOLD | F_KRDY, 5'd0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_dload", F_BUSY | F_HOLD | F_DLD | F_KRDY, 5'd0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("rst_dround%0d", i), F_BUSY | F_HOLD | F_DRND | F_KRDY, 5'(31 - i), 6'(i));
        end
        #1;
        rest = 1'b1;
        #1;
        chk("async_reset", 10'h000, 5'd0, 6'd0);
        @(posedge clk);
        #2;
        rest = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after_async", 10'h000, 5'd0, 6'd0);
        run_op("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
